// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- parametrised oversampling UART receiver.
//
// Receives DATA_BITS-wide frames, LSB first, from the rx line. The line is
// sampled at mid-bit using OVERSAMPLE s_tick pulses per bit period. Parity
// and stop-bit count can be changed at runtime, but they are captured when
// the start edge is detected. A completed word is held in output registers
// until rx_rd acknowledges it.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   s_tick       oversample enable, one clk wide
//   parity_mode  00/11 none, 01 even, 10 odd
//   two_stop     1 = two stop bits checked
//   rx_rd        consumer acknowledge of held data
//   rx_data      received word
//   rx_valid     held word available (level)
//   parity_err   parity mismatch for held word
//   frame_err    a stop bit was sampled low for held word
//   break_det    break condition for held word
//   overrun_err  a word was lost since the last rx_rd (sticky)
module uart_rx_ext #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 s_tick,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic [SW-1:0]          r_s_cnt, w_s_cnt_n;
  logic [NW-1:0]          r_n_cnt, w_n_cnt_n;
  logic [DATA_BITS-1:0]   r_shreg, w_shreg_n;
  logic [1:0]             r_pmode, w_pmode_n;
  logic                   r_two, w_two_n;
  logic                   r_pbit, w_pbit_n;
  logic                   r_perr, w_perr_n;
  logic                   r_ferr, w_ferr_n;
  logic                   r_stop2, w_stop2_n;
  logic                   w_par_en, w_odd;
  logic                   w_done, w_done_ferr, w_done_brk;

  assign w_rx_s   = r_sync[SYNC_STAGES-1];
  assign w_par_en = ^r_pmode;          // 01 or 10
  assign w_odd    = (r_pmode == 2'b10);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '1;
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shreg <= '0;
      r_pmode <= '0;
      r_two   <= 1'b0;
      r_pbit  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_stop2 <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
      r_state <= w_state_n;
      r_s_cnt <= w_s_cnt_n;
      r_n_cnt <= w_n_cnt_n;
      r_shreg <= w_shreg_n;
      r_pmode <= w_pmode_n;
      r_two   <= w_two_n;
      r_pbit  <= w_pbit_n;
      r_perr  <= w_perr_n;
      r_ferr  <= w_ferr_n;
      r_stop2 <= w_stop2_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_s_cnt_n   = r_s_cnt;
    w_n_cnt_n   = r_n_cnt;
    w_shreg_n   = r_shreg;
    w_pmode_n   = r_pmode;
    w_two_n     = r_two;
    w_pbit_n    = r_pbit;
    w_perr_n    = r_perr;
    w_ferr_n    = r_ferr;
    w_stop2_n   = r_stop2;
    w_done      = 1'b0;
    w_done_ferr = r_ferr;
    w_done_brk  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_n = START;
          w_s_cnt_n = '0;
          w_pmode_n = parity_mode;
          w_two_n   = two_stop;
        end
      end

      START: begin
        if (s_tick) begin
          if (r_s_cnt == S_MID) begin
            if (w_rx_s) begin
              w_state_n = IDLE;        // glitch, not a real start bit
            end else begin
              w_state_n = DATA;
              w_s_cnt_n = '0;
              w_n_cnt_n = '0;
              w_pbit_n  = 1'b0;
              w_perr_n  = 1'b0;
              w_ferr_n  = 1'b0;
              w_stop2_n = 1'b0;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (r_s_cnt == S_LAST) begin
            w_shreg_n = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            w_s_cnt_n = '0;
            if (r_n_cnt == N_LAST) begin
              w_state_n = w_par_en ? PARITY : STOP;
            end else begin
              w_n_cnt_n = r_n_cnt + 1'b1;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + 1'b1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (r_s_cnt == S_LAST) begin
            w_pbit_n  = w_rx_s;
            w_perr_n  = (^r_shreg) ^ w_rx_s ^ w_odd;
            w_s_cnt_n = '0;
            w_state_n = STOP;
          end else begin
            w_s_cnt_n = r_s_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (r_s_cnt == S_LAST) begin
            w_s_cnt_n = '0;
            // Break is decided on the first stop sample; r_pbit is 0 when
            // parity is disabled, so one test covers both frame formats.
            if (!r_stop2 && !w_rx_s && (r_shreg == '0) && !r_pbit) begin
              w_done      = 1'b1;
              w_done_ferr = 1'b1;
              w_done_brk  = 1'b1;
              w_state_n   = BRK_WAIT;
            end else if (!r_stop2 && r_two) begin
              w_stop2_n = 1'b1;
              w_ferr_n  = r_ferr | ~w_rx_s;
            end else begin
              w_done      = 1'b1;
              w_done_ferr = r_ferr | ~w_rx_s;
              w_state_n   = IDLE;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + 1'b1;
          end
        end
      end

      BRK_WAIT: begin
        if (w_rx_s) begin
          w_state_n = IDLE;
        end
      end

      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (w_done) begin
      rx_data    <= r_shreg;
      parity_err <= r_perr;
      frame_err  <= w_done_ferr;
      break_det  <= w_done_brk;
      rx_valid   <= 1'b1;
      // A pending word is lost unless it is being acknowledged this cycle.
      if (rx_valid) begin
        overrun_err <= ~rx_rd;
      end
    end else if (rx_rd && rx_valid) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;

  localparam int DB      = 8;
  localparam int OS      = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OS * TDIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          s_tick = 1'b0;
  logic [1:0]    parity_mode = 2'b00;
  logic          two_stop = 1'b0;
  logic          rx_rd = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          break_det;
  logic          overrun_err;

  uart_rx_ext #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .s_tick     (s_tick),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .rx_rd      (rx_rd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
    logic          bk;
    logic          ov;
  } word_t;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Monitor: a word is presented when rx_valid rises, or when the held
  // contents change while rx_valid stays high (overwrite on overrun).
  initial begin
    word_t cur;
    word_t prev;
    word_t e;
    logic  prev_v;
    prev   = '0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cur = {rx_data, parity_err, frame_err, break_det, overrun_err};
      if (rx_valid && (!prev_v || cur != prev)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word: got d=%h pe=%b fe=%b bk=%b ov=%b, none expected",
                   cur.d, cur.pe, cur.fe, cur.bk, cur.ov);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++;
            $display("FAIL word: got d=%h pe=%b fe=%b bk=%b ov=%b, expected d=%h pe=%b fe=%b bk=%b ov=%b",
                     cur.d, cur.pe, cur.fe, cur.bk, cur.ov, e.d, e.pe, e.fe, e.bk, e.ov);
          end
        end
      end
      prev   = cur;
      prev_v = rx_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [DB-1:0] d, input logic pe, input logic fe,
                             input logic bk, input logic ov);
    word_t w;
    w = {d, pe, fe, bk, ov};
    exp_q.push_back(w);
  endtask

  task automatic bitp(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  // Sends one frame; config inputs are disturbed after the first data bit
  // so a receiver that does not hold the start-time config misbehaves.
  // A final stop bit of 0 is shortened so it cannot look like a new start.
  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic two,
                            input logic pbit, input logic st1, input logic st2);
    parity_mode = pm;
    two_stop    = two;
    bitp(1'b0, BIT_CLK);
    for (int i = 0; i < DB; i++) begin
      bitp(d[i], BIT_CLK);
      if (i == 0) begin
        parity_mode = pm ^ 2'b01;
        two_stop    = ~two;
      end
    end
    if (^pm) bitp(pbit, BIT_CLK);
    if (two) begin
      bitp(st1, BIT_CLK);
      bitp(st2, st2 ? BIT_CLK : 40);
    end else begin
      bitp(st1, st1 ? BIT_CLK : 40);
    end
    rx          = 1'b1;
    parity_mode = pm;
    two_stop    = two;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * BIT_CLK) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic do_read(input logic [DB-1:0] d_hold);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    check("rd_valid", rx_valid, 0);
    check("rd_overrun", overrun_err, 0);
    check("rd_data_hold", rx_data, d_hold);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_brk"}, break_det, 0);
    check({tag, "_ovr"}, overrun_err, 0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // 8N1 basic word
    expect_word(8'hA5, 0, 0, 0, 0);
    send_frame(8'hA5, 2'b00, 0, 0, 1, 1);
    drain();
    do_read(8'hA5);

    // 0x37 has five ones: even wants parity 1, odd wants parity 0
    expect_word(8'h37, 1, 0, 0, 0);
    send_frame(8'h37, 2'b01, 0, 0, 1, 1);
    drain();
    do_read(8'h37);
    expect_word(8'h37, 0, 0, 0, 0);
    send_frame(8'h37, 2'b01, 0, 1, 1, 1);
    drain();
    do_read(8'h37);
    expect_word(8'h37, 0, 0, 0, 0);
    send_frame(8'h37, 2'b10, 0, 0, 1, 1);
    drain();
    do_read(8'h37);
    expect_word(8'h37, 1, 0, 0, 0);
    send_frame(8'h37, 2'b10, 0, 1, 1, 1);
    drain();
    do_read(8'h37);

    // two stop bits, second one low
    expect_word(8'h55, 0, 1, 0, 0);
    send_frame(8'h55, 2'b00, 1, 0, 1, 0);
    drain();
    do_read(8'h55);

    // start glitch of 5 ticks, then a good frame
    rx = 1'b0;
    repeat (5 * TDIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("glitch_no_valid", rx_valid, 0);
    expect_word(8'h3C, 0, 0, 0, 0);
    send_frame(8'h3C, 2'b00, 0, 0, 1, 1);
    drain();
    do_read(8'h3C);

    // break: line low for 20 bit periods gives exactly one word
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    expect_word(8'h00, 0, 1, 1, 0);
    bitp(1'b0, 20 * BIT_CLK);
    check("break_valid_while_low", rx_valid, 1);
    rx = 1'b1;
    drain();
    do_read(8'h00);

    // back-to-back words without acknowledge
    expect_word(8'h11, 0, 0, 0, 0);
    expect_word(8'h22, 0, 0, 0, 1);
    send_frame(8'h11, 2'b00, 0, 0, 1, 1);
    send_frame(8'h22, 2'b00, 0, 0, 1, 1);
    drain();
    check("overrun_set", overrun_err, 1);
    do_read(8'h22);

    // reset in the middle of the data bits
    bitp(1'b0, BIT_CLK);
    bitp(1'b1, BIT_CLK);
    bitp(1'b0, BIT_CLK / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("midreset_no_word", rx_valid, 0);
    expect_word(8'h96, 0, 0, 0, 0);
    send_frame(8'h96, 2'b00, 0, 0, 1, 1);
    drain();
    do_read(8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
